// File: rtl/spi_flash_read_master.sv
// SPI flash READ master: shifts out command and address, then collects len bytes from MISO.
// Every SCK edge is paced by the externally divided sub_clock and its low-phase strobe.
module spi_flash_read_master #(
    parameter logic [7:0]  READ_CMD = 8'h03,
    parameter int unsigned ADDR_W   = 24,
    parameter int unsigned LEN_W    = 8
) (
    input  logic              top_clk,
    input  logic              reset,
    input  logic              sub_clock,
    input  logic              si_strobe,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              flash_miso,
    output logic              flash_cs_n,
    output logic              flash_sck,
    output logic              flash_mosi,
    output logic [7:0]        data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              done
);
    localparam int unsigned CNT_W = $clog2((ADDR_W > 8) ? ADDR_W : 8);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_STOP} state_t;

    state_t             state_q, state_d;
    logic               cs_n_q, cs_n_d;
    logic               sck_en_q, sck_en_d;
    logic               mosi_q, mosi_d;
    logic [7:0]         data_out_q, data_out_d;
    logic               data_valid_q, data_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sub_clock_q;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [6:0]         shreg_q, shreg_d;
    logic               rise;

    // Enable only toggles during the sub_clock low phase, so the gated clock never glitches.
    assign flash_sck  = sub_clock & sck_en_q;
    assign flash_cs_n = cs_n_q;
    assign flash_mosi = mosi_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

    always_comb begin
        rise         = sub_clock & ~sub_clock_q & sck_en_q;
        state_d      = state_q;
        cs_n_d       = cs_n_q;
        sck_en_d     = sck_en_q;
        mosi_d       = mosi_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        bit_cnt_d    = bit_cnt_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        shreg_d      = shreg_q;
        case (state_q)
            S_IDLE: begin
                busy_d   = 1'b0;
                sck_en_d = 1'b0;
                if (start) begin
                    busy_d = 1'b1;
                    if (len != '0) begin
                        addr_d      = addr;
                        remaining_d = len;
                        cs_n_d      = 1'b0;
                        bit_cnt_d   = '0;
                        state_d     = S_CMD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_CMD: begin
                if (si_strobe) begin
                    mosi_d   = READ_CMD[~bit_cnt_q[2:0]];
                    sck_en_d = 1'b1;
                end
                if (rise) begin
                    if (bit_cnt_q == CNT_W'(7)) begin
                        bit_cnt_d = '0;
                        state_d   = S_ADDR;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_ADDR: begin
                if (si_strobe) begin
                    mosi_d   = addr_q[CNT_W'(ADDR_W - 1) - bit_cnt_q];
                    sck_en_d = 1'b1;
                end
                if (rise) begin
                    if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = S_DATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (si_strobe) begin
                    mosi_d = 1'b0;
                end
                if (rise) begin
                    shreg_d = {shreg_q[5:0], flash_miso};
                    if (bit_cnt_q == CNT_W'(7)) begin
                        data_out_d   = {shreg_q, flash_miso};
                        data_valid_d = 1'b1;
                        remaining_d  = remaining_q - LEN_W'(1);
                        bit_cnt_d    = '0;
                        if (remaining_q == LEN_W'(1)) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_STOP: begin
                // Wait for the low-phase strobe so SCK is low when the gate closes.
                if (si_strobe) begin
                    sck_en_d = 1'b0;
                    cs_n_d   = 1'b1;
                    mosi_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge top_clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cs_n_q       <= 1'b1;
            sck_en_q     <= 1'b0;
            mosi_q       <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sub_clock_q  <= 1'b0;
            bit_cnt_q    <= '0;
            addr_q       <= '0;
            remaining_q  <= '0;
            shreg_q      <= '0;
        end else begin
            state_q      <= state_d;
            cs_n_q       <= cs_n_d;
            sck_en_q     <= sck_en_d;
            mosi_q       <= mosi_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            sub_clock_q  <= sub_clock;
            bit_cnt_q    <= bit_cnt_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            shreg_q      <= shreg_d;
        end
    end
endmodule

// File: tb/tb_spi_flash_read_master.sv
// Bench for spi_flash_read_master: behavioural flash + divider model, per-scenario checks.
module tb_spi_flash_read_master;
    logic        top_clk = 1'b0;
    logic        reset = 1'b1;
    logic        sub_clock = 1'b0;
    logic        si_strobe = 1'b0;
    logic        start = 1'b0;
    logic [23:0] addr = '0;
    logic [7:0]  len = '0;
    logic        flash_miso = 1'b0;
    logic        flash_cs_n, flash_sck, flash_mosi, data_valid, busy, done;
    logic [7:0]  data_out;

    int checks = 0;
    int errors = 0;
    int period = 4;
    int rise_total = 0, rise_base = 0, sck_bad = 0, done_total = 0, overlap = 0, cur_len = 0;
    logic       mosi_bits[$];
    logic [7:0] valid_bytes[$];
    logic [7:0] flash_bytes[256];

    int          o_rises, o_tail_ones, o_nvalid, o_vbase, o_ndone, o_bad, o_ov;
    logic [31:0] o_cmd_addr;
    logic        o_busy_start, o_busy_end, o_cs_end, o_timeout;

    spi_flash_read_master dut (
        .top_clk(top_clk), .reset(reset), .sub_clock(sub_clock), .si_strobe(si_strobe),
        .start(start), .addr(addr), .len(len), .flash_miso(flash_miso),
        .flash_cs_n(flash_cs_n), .flash_sck(flash_sck), .flash_mosi(flash_mosi),
        .data_out(data_out), .data_valid(data_valid), .busy(busy), .done(done)
    );

    always #5 top_clk = ~top_clk;

    // Divider model: sub_clock high on the last phase, strobe on phase 1 of the low part.
    initial begin : divider
        int ph;
        ph = 0;
        forever begin
            @(negedge top_clk);
            ph = (ph + 1 >= period) ? 0 : ph + 1;
            sub_clock = (ph == period - 1);
            si_strobe = (ph == 1);
        end
    end

    always @(posedge flash_sck) begin
        mosi_bits.push_back(flash_mosi);
        rise_total++;
        if (flash_cs_n) sck_bad++;
    end

    // Flash: after command+address, present the stored bytes MSB first, changing on falling SCK.
    always @(negedge flash_sck) begin : flash_model
        int idx;
        logic [7:0] b;
        idx = rise_total - rise_base - 32;
        if (idx >= 0 && idx < 8 * cur_len) begin
            b = flash_bytes[8'(idx / 8)];
            flash_miso = b[3'(7 - idx % 8)];
        end else begin
            flash_miso = 1'b0;
        end
    end

    always @(negedge top_clk) begin
        if (data_valid) valid_bytes.push_back(data_out);
        if (done) done_total++;
        if (done && data_valid) overlap++;
    end

    // Runs one read (optionally with a stray start during ADDR) and records what was seen.
    task automatic do_read(input logic [23:0] a, input int n, input bit inject);
        int dbase, bbase, obase, wc, budget;
        rise_base = rise_total;
        cur_len   = n;
        o_vbase   = valid_bytes.size();
        dbase     = done_total;
        bbase     = sck_bad;
        obase     = overlap;
        budget    = (40 + 8 * n) * (period + 1) + 50;
        o_timeout = 1'b0;
        @(posedge top_clk); #1;
        start = 1'b1; addr = a; len = 8'(n);
        @(posedge top_clk); #1;
        start = 1'b0; addr = 24'($urandom); len = 8'($urandom);
        o_busy_start = busy;
        if (inject) begin
            wc = 0;
            while (rise_total - rise_base < 18 && wc < budget) begin
                @(posedge top_clk); #1; wc++;
            end
            start = 1'b1; addr = 24'hFFFFFF; len = 8'd9;
            @(posedge top_clk); #1;
            start = 1'b0;
        end
        wc = 0;
        while (done_total == dbase && wc < budget) begin
            @(posedge top_clk); #1; wc++;
        end
        if (wc >= budget) o_timeout = 1'b1;
        o_rises    = rise_total - rise_base;
        o_cmd_addr = '0;
        o_tail_ones = 0;
        for (int i = 0; rise_base + i < mosi_bits.size(); i++) begin
            if (i < 32) o_cmd_addr = {o_cmd_addr[30:0], mosi_bits[rise_base + i]};
            else if (mosi_bits[rise_base + i] === 1'b1) o_tail_ones++;
        end
        o_nvalid   = valid_bytes.size() - o_vbase;
        o_ndone    = done_total - dbase;
        o_bad      = sck_bad - bbase;
        o_ov       = overlap - obase;
        o_busy_end = busy;
        o_cs_end   = flash_cs_n;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge top_clk);
        @(negedge top_clk) reset = 1'b0;
        repeat (5) @(posedge top_clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (flash_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", flash_cs_n); end
        checks++; if (flash_sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", flash_sck); end
        checks++; if (flash_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", flash_mosi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_out); end
        repeat (2) @(posedge top_clk);
        @(negedge top_clk) reset = 1'b0;
        repeat (3) @(posedge top_clk);
        #1;
        checks++; if (flash_cs_n !== 1'b1) begin errors++; $display("FAIL idle_cs_n: got %b expected 1", flash_cs_n); end
    endtask

    task automatic test_basic(input string tag, input bit inject);
        period = 4;
        flash_bytes[0] = 8'hA5;
        flash_bytes[1] = 8'h3C;
        do_read(24'h123456, 2, inject);
        checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL %s_timeout: no done within budget", tag); end
        checks++; if (o_rises !== 48) begin errors++; $display("FAIL %s_rises: got %0d expected 48", tag, o_rises); end
        checks++; if (o_cmd_addr !== 32'h03123456) begin errors++; $display("FAIL %s_mosi: got %h expected 03123456", tag, o_cmd_addr); end
        checks++; if (o_tail_ones !== 0) begin errors++; $display("FAIL %s_mosi_data: got %0d ones expected 0", tag, o_tail_ones); end
        checks++; if (o_nvalid !== 2) begin errors++; $display("FAIL %s_nvalid: got %0d expected 2", tag, o_nvalid); end
        for (int i = 0; i < 2 && i < o_nvalid; i++) begin
            checks++; if (valid_bytes[o_vbase + i] !== flash_bytes[i]) begin errors++; $display("FAIL %s_byte%0d: got %h expected %h", tag, i, valid_bytes[o_vbase + i], flash_bytes[i]); end
        end
        checks++; if (o_ndone !== 1) begin errors++; $display("FAIL %s_done: got %0d expected 1", tag, o_ndone); end
        checks++; if (o_bad !== 0) begin errors++; $display("FAIL %s_sck_cs: got %0d expected 0", tag, o_bad); end
        checks++; if (o_ov !== 0) begin errors++; $display("FAIL %s_overlap: got %0d expected 0", tag, o_ov); end
        checks++; if (o_busy_start !== 1'b1) begin errors++; $display("FAIL %s_busy_start: got %b expected 1", tag, o_busy_start); end
        checks++; if (o_busy_end !== 1'b0) begin errors++; $display("FAIL %s_busy_end: got %b expected 0", tag, o_busy_end); end
        checks++; if (o_cs_end !== 1'b1) begin errors++; $display("FAIL %s_cs_end: got %b expected 1", tag, o_cs_end); end
    endtask

    task automatic test_len0();
        int rb, db;
        rb = rise_total;
        db = done_total;
        @(posedge top_clk); #1;
        start = 1'b1; len = 8'd0; addr = 24'($urandom);
        @(posedge top_clk); #1;
        start = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL len0_done: got %b expected 1", done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL len0_busy: got %b expected 1", busy); end
        checks++; if (flash_cs_n !== 1'b1) begin errors++; $display("FAIL len0_cs_n: got %b expected 1", flash_cs_n); end
        @(posedge top_clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL len0_done_end: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy_end: got %b expected 0", busy); end
        repeat (3 * period) @(posedge top_clk);
        #1;
        checks++; if (rise_total !== rb) begin errors++; $display("FAIL len0_rises: got %0d expected %0d", rise_total - rb, 0); end
        checks++; if (done_total - db !== 1) begin errors++; $display("FAIL len0_done_count: got %0d expected 1", done_total - db); end
        checks++; if (flash_cs_n !== 1'b1) begin errors++; $display("FAIL len0_cs_idle: got %b expected 1", flash_cs_n); end
    endtask

    task automatic test_reset_mid();
        int db, wc;
        period = 4;
        flash_bytes[0] = 8'hA5;
        flash_bytes[1] = 8'h3C;
        cur_len = 2;
        rise_base = rise_total;
        db = done_total;
        @(posedge top_clk); #1;
        start = 1'b1; addr = 24'h123456; len = 8'd2;
        @(posedge top_clk); #1;
        start = 1'b0;
        wc = 0;
        while (rise_total - rise_base < 18 && wc < 500) begin
            @(posedge top_clk); #1; wc++;
        end
        checks++; if (wc >= 500) begin errors++; $display("FAIL midreset_reach: got %0d rises expected 18", rise_total - rise_base); end
        #2 reset = 1'b1;
        #1;
        checks++; if (flash_cs_n !== 1'b1) begin errors++; $display("FAIL midreset_cs_n: got %b expected 1", flash_cs_n); end
        checks++; if (flash_sck !== 1'b0) begin errors++; $display("FAIL midreset_sck: got %b expected 0", flash_sck); end
        repeat (4) @(posedge top_clk);
        #1;
        checks++; if (done_total !== db) begin errors++; $display("FAIL midreset_done: got %0d expected 0", done_total - db); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        @(negedge top_clk) reset = 1'b0;
        test_basic("rerun", 1'b0);
    endtask

    task automatic test_random();
        logic [23:0] a;
        int n;
        for (int t = 0; t < 6; t++) begin
            period = $urandom_range(4, 7);
            a = 24'($urandom);
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) flash_bytes[i] = 8'($urandom);
            do_read(a, n, 1'b0);
            checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL rand%0d_timeout: no done within budget", t); end
            checks++; if (o_rises !== 32 + 8 * n) begin errors++; $display("FAIL rand%0d_rises: got %0d expected %0d", t, o_rises, 32 + 8 * n); end
            checks++; if (o_cmd_addr !== {8'h03, a}) begin errors++; $display("FAIL rand%0d_mosi: got %h expected %h", t, o_cmd_addr, {8'h03, a}); end
            checks++; if (o_nvalid !== n) begin errors++; $display("FAIL rand%0d_nvalid: got %0d expected %0d", t, o_nvalid, n); end
            for (int i = 0; i < n && i < o_nvalid; i++) begin
                checks++; if (valid_bytes[o_vbase + i] !== flash_bytes[i]) begin errors++; $display("FAIL rand%0d_byte%0d: got %h expected %h", t, i, valid_bytes[o_vbase + i], flash_bytes[i]); end
            end
            checks++; if (o_ndone !== 1 || o_ov !== 0 || o_bad !== 0) begin errors++; $display("FAIL rand%0d_framing: got done=%0d overlap=%0d sck_cs=%0d expected 1/0/0", t, o_ndone, o_ov, o_bad); end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] a;
        for (int t = 0; t < 3; t++) begin
            period = 5;
            a = 24'($urandom);
            flash_bytes[0] = 8'($urandom);
            do_read(a, 1, 1'b0);
            checks++; if (o_cmd_addr !== {8'h03, a} || o_rises !== 40) begin errors++; $display("FAIL b2b%0d_frame: got %h/%0d expected %h/40", t, o_cmd_addr, o_rises, {8'h03, a}); end
            checks++; if (o_nvalid !== 1 || valid_bytes[valid_bytes.size() - 1] !== flash_bytes[0]) begin errors++; $display("FAIL b2b%0d_data: got n=%0d last=%h expected 1/%h", t, o_nvalid, valid_bytes[valid_bytes.size() - 1], flash_bytes[0]); end
        end
    endtask

    task automatic test_len255();
        logic [23:0] a;
        int bad_bytes;
        period = 4;
        a = 24'($urandom);
        for (int i = 0; i < 255; i++) flash_bytes[i] = 8'(i);
        do_read(a, 255, 1'b0);
        checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL len255_timeout: no done within budget"); end
        checks++; if (o_rises !== 32 + 8 * 255) begin errors++; $display("FAIL len255_rises: got %0d expected %0d", o_rises, 32 + 8 * 255); end
        checks++; if (o_nvalid !== 255) begin errors++; $display("FAIL len255_nvalid: got %0d expected 255", o_nvalid); end
        bad_bytes = 0;
        for (int i = 0; i < 255 && i < o_nvalid; i++) if (valid_bytes[o_vbase + i] !== 8'(i)) bad_bytes++;
        checks++; if (bad_bytes !== 0) begin errors++; $display("FAIL len255_order: got %0d wrong bytes expected 0", bad_bytes); end
        checks++; if (o_bad !== 0 || o_ndone !== 1) begin errors++; $display("FAIL len255_framing: got sck_cs=%0d done=%0d expected 0/1", o_bad, o_ndone); end
    endtask

    initial begin
        test_reset();
        test_basic("basic", 1'b0);
        test_len0();
        test_basic("ignore_start", 1'b1);
        test_reset_mid();
        test_random();
        test_back_to_back();
        test_len255();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
